// File: rtl/mem_access_pkg.sv
// Shared encodings, store-buffer entry type and small decode helpers
// for the load/store unit and its store buffer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_BYTE = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    size_e       size;
  } sb_entry_t;

  function automatic logic is_fault(input size_e size, input logic [1:0] lo);
    logic f;
    case (size)
      SIZE_WORD: f = (lo != 2'b00);
      SIZE_HALF: f = lo[0];
      SIZE_BYTE: f = 1'b0;
      default:   f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] we_code(input size_e size);
    logic [1:0] c;
    case (size)
      SIZE_WORD: c = WE_WORD;
      SIZE_HALF: c = WE_HALF;
      SIZE_BYTE: c = WE_BYTE;
      default:   c = WE_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input size_e size, input logic zext);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = word[{lo[1], 4'b0000} +: 16];
    b = word[{lo, 3'b000} +: 8];
    case (size)
      SIZE_HALF: r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
      SIZE_BYTE: r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_sb_fifo.sv
// Store buffer: circular FIFO of pending stores with a word-address
// compare across all occupied entries for load hazard detection.
module sb_fifo
  import mem_access_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [29:0] cmp_waddr,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty,
  output logic        match
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  sb_entry_t       entries_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic            push_ok_s;
  logic            pop_ok_s;
  logic [PW-1:0]   off_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign head      = entries_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer, occupancy and entry storage update; pointers wrap by width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        entries_r[wr_ptr_r] <= push_entry;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW + 1)'(1);
        2'b01:   count_r <= count_r - (PW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    match = 1'b0;
    off_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s = PW'(i) - rd_ptr_r;
      match = match | (({1'b0, off_s} < count_r) && (entries_r[i].addr[31:2] == cmp_waddr));
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment checking, store buffering with load hazard
// stalls, single-port data-memory arbitration and load data extension.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        misalign,
  output logic        sb_empty,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  size_e       size_s;
  logic        fault_s;
  logic        ready_s;
  logic        load_acc_s;
  logic        store_acc_s;
  logic        fault_acc_s;
  logic        drain_s;
  logic        sb_full_s;
  logic        sb_empty_s;
  logic        sb_match_s;
  sb_entry_t   head_s;
  sb_entry_t   push_entry_s;
  logic        resp_valid_r;
  logic        misalign_r;
  logic [31:0] resp_data_r;
  logic [4:0]  resp_rd_r;

  sb_fifo #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push       (store_acc_s),
    .push_entry (push_entry_s),
    .pop        (drain_s),
    .cmp_waddr  (req_addr[31:2]),
    .head       (head_s),
    .full       (sb_full_s),
    .empty      (sb_empty_s),
    .match      (sb_match_s)
  );

  // Request acceptance and memory-port arbitration. A full buffer blocks
  // every aligned request, so draining automatically wins in that case.
  always_comb begin
    size_s  = size_e'(req_size);
    fault_s = is_fault(size_s, req_addr[1:0]);
    if (!reset) begin
      ready_s = 1'b0;
    end else if (fault_s) begin
      ready_s = 1'b1;
    end else if (req_load) begin
      ready_s = !sb_full_s && !sb_match_s;
    end else begin
      ready_s = !sb_full_s;
    end
    fault_acc_s  = req_valid && ready_s && fault_s;
    load_acc_s   = req_valid && ready_s && !fault_s && req_load;
    store_acc_s  = req_valid && ready_s && !fault_s && !req_load;
    drain_s      = !sb_empty_s && !load_acc_s;
    push_entry_s = '{addr: req_addr, data: req_wdata, size: size_s};
    if (drain_s) begin
      mem_we = we_code(head_s.size);
      mem_a  = head_s.addr;
    end else begin
      mem_we = WE_NONE;
      mem_a  = req_addr;
    end
    mem_wd = head_s.data;
  end

  // Response register: one-cycle pulse for each accepted load or fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      resp_rd_r    <= 5'd0;
    end else begin
      resp_valid_r <= load_acc_s || fault_acc_s;
      misalign_r   <= fault_acc_s;
      resp_data_r  <= load_acc_s ? load_extract(mem_rd, req_addr[1:0], size_s, req_unsigned)
                                 : 32'h0000_0000;
      resp_rd_r    <= (load_acc_s || fault_acc_s) ? req_rd : 5'd0;
    end
  end

  assign req_ready  = ready_s;
  assign sb_empty   = sb_empty_s;
  assign resp_valid = resp_valid_r;
  assign misalign   = misalign_r;
  assign resp_data  = resp_data_r;
  assign resp_rd    = resp_rd_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a program-order
// memory model with an outstanding-store queue.
module tb_mem_access_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        misalign;
  logic        sb_empty;
  logic [1:0]  mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] phys [64];
  logic [31:0] arch [64];
  typedef struct { logic [31:0] a; logic [31:0] d; logic [1:0] sz; } st_t;
  st_t q[$];
  logic [31:0] last_data;
  logic        last_mis;

  always #5 clk = ~clk;

  mem_access_unit #(.SB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .misalign(misalign), .sb_empty(sb_empty), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = phys[mem_a[7:2]];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : ((sz == 2'b01) ? 2 : 1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] lo, input int nb);
    logic [31:0] r = old;
    for (int k = 0; k < nb; k++) r[8*((int'(lo) + k) % 4) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic ref_fault(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b00 && lo != 2'b00) || (sz == 2'b01 && lo[0]);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic u);
    logic [31:0] v = w >> (8 * int'(lo));
    if (nbytes(sz) == 4) return w;
    if (nbytes(sz) == 2) return u ? (v & 32'h0000_FFFF) : 32'($signed(v[15:0]));
    return u ? (v & 32'h0000_00FF) : 32'($signed(v[7:0]));
  endfunction

  function automatic logic [1:0] ref_we(input logic [1:0] sz);
    return (nbytes(sz) == 4) ? 2'b01 : ((nbytes(sz) == 2) ? 2'b10 : 2'b11);
  endfunction

  // Environment data memory applies DUT writes at the clock edge.
  always @(posedge clk) begin
    if (mem_we != 2'b00)
      phys[mem_a[7:2]] <= merge(phys[mem_a[7:2]], mem_wd, mem_a[1:0],
                                (mem_we == 2'b01) ? 4 : ((mem_we == 2'b10) ? 2 : 1));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic ld, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      output logic acc);
    logic exp_ready, fault, hit, load_acc, exp_resp;
    logic [31:0] exp_data;
    @(negedge clk);
    req_valid = v; req_load = ld; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; req_rd = rd;
    #1;
    fault = ref_fault(sz, a[1:0]);
    hit = 1'b0;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) hit = 1'b1;
    if (fault) exp_ready = 1'b1;
    else if (ld) exp_ready = !hit && (q.size() < DEPTH);
    else exp_ready = (q.size() < DEPTH);
    if (v) check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = v && exp_ready;
    load_acc = acc && ld && !fault;
    if (q.size() > 0 && !load_acc) begin
      check_eq("drain_we", 32'(mem_we), 32'(ref_we(q[0].sz)));
      check_eq("drain_a", mem_a, q[0].a);
      check_eq("drain_wd", mem_wd, q[0].d);
      void'(q.pop_front());
    end else begin
      check_eq("idle_we", 32'(mem_we), 32'h0);
    end
    if (load_acc) check_eq("load_a", mem_a, a);
    exp_resp = acc && (ld || fault);
    exp_data = load_acc ? ref_load(arch[a[7:2]], a[1:0], sz, u) : 32'h0;
    if (acc && !ld && !fault) begin
      q.push_back('{a: a, d: wd, sz: sz});
      arch[a[7:2]] = merge(arch[a[7:2]], wd, a[1:0], nbytes(sz));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("resp_valid", 32'(resp_valid), 32'(exp_resp));
    if (exp_resp) begin
      check_eq("misalign", 32'(misalign), 32'(fault));
      check_eq("resp_data", resp_data, exp_data);
      check_eq("resp_rd", 32'(resp_rd), 32'(rd));
    end
    check_eq("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    last_data = resp_data;
    last_mis  = misalign;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, acc);
  endtask

  initial begin
    logic acc;
    int tries;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      phys[i] = $urandom;
      arch[i] = phys[i];
    end
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_empty", 32'(sb_empty), 32'h1);
    check_eq("rst_we", 32'(mem_we), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_misalign", 32'(misalign), 32'h0);
    check_eq("rst_resp_data", resp_data, 32'h0);
    check_eq("rst_resp_rd", 32'(resp_rd), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Store word then idle: drain next cycle.
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, acc);
    check_eq("sw_acc", 32'(acc), 32'h1);
    idle(2);

    // Load extraction on a known word.
    phys[8] = 32'h8765_43F0;
    arch[8] = 32'h8765_43F0;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 5'd3, acc);
    check_eq("lb_signed", last_data, 32'hFFFF_FFF0);
    step(1'b1, 1'b1, 2'b10, 1'b1, 32'h20, 32'h0, 5'd4, acc);
    check_eq("lbu", last_data, 32'h0000_00F0);
    step(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0, 5'd5, acc);
    check_eq("lh_signed", last_data, 32'hFFFF_8765);

    // Load right after a store to the same word stalls until drained.
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'hCAFE_F00D, 5'd0, acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 8) begin
      step(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, 5'd7, acc);
      tries++;
    end
    check_eq("raw_accepted", 32'(acc), 32'h1);
    check_eq("raw_stalled", 32'(tries > 1), 32'h1);
    check_eq("raw_data", last_data, 32'hCAFE_F00D);

    // Back-to-back stores interleaved with loads to other words.
    for (int s = 0; s < 3; s++) begin
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 8) begin
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h80 + 32'(4 * s), 32'h1111_0000 + 32'(s), 5'd0, acc);
        tries++;
      end
      check_eq("b2b_store_acc", 32'(acc), 32'h1);
      step(1'b1, 1'b1, 2'b00, 1'b0, 32'(4 * s), 32'h0, 5'(s + 1), acc);
    end
    idle(3);
    check_eq("b2b_mem0", phys[32], 32'h1111_0000);
    check_eq("b2b_mem2", phys[34], 32'h1111_0002);

    // Faults: misaligned word, misaligned half, illegal size.
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 5'd9, acc);
    check_eq("flt_lw_mis", 32'(last_mis), 32'h1);
    step(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h5555, 5'd10, acc);
    check_eq("flt_sh_mis", 32'(last_mis), 32'h1);
    step(1'b1, 1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 5'd11, acc);
    check_eq("flt_ill_data", last_data, 32'h0);

    // Random traffic over a small address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      sz = ($urandom % 10 == 0) ? 2'b11 : 2'($urandom % 3);
      a  = 32'($urandom_range(0, 63));
      if ($urandom % 6 != 0) begin
        if (sz == 2'b00) a[1:0] = 2'b00;
        if (sz == 2'b01) a[0] = 1'b0;
      end
      wd = $urandom;
      step(($urandom % 8) != 0, 1'($urandom % 2), sz, 1'($urandom % 2), a, wd,
           5'($urandom % 32), acc);
    end
    idle(3);

    // Reset with stores pending: nothing may reach memory afterwards.
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'hBAD0_BAD0, 5'd0, acc);
    reset = 1'b0;
    q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check_eq("rst_mid_we", 32'(mem_we), 32'h0);
      check_eq("rst_mid_empty", 32'(sb_empty), 32'h1);
      check_eq("rst_mid_resp", 32'(resp_valid), 32'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 64; i++) arch[i] = phys[i];
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
